// File: rtl/regfile_mp.sv
// Multi-port MIPS register file: two write lanes (lane 1 wins on collision),
// NUM_RD independent read ports, optional write-to-read bypass and registered read stage.
module regfile_mp #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ADDR_WIDTH   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned BYPASS       = 1,
  parameter int unsigned ZERO_REG     = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         we0,
  input  logic [ADDR_WIDTH-1:0]        wa0,
  input  logic [DATA_WIDTH-1:0]        wd0,
  input  logic                         we1,
  input  logic [ADDR_WIDTH-1:0]        wa1,
  input  logic [DATA_WIDTH-1:0]        wd1,
  output logic                         wr_conflict
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
  logic                  conflict_q;
  logic                  conflict_d;
  logic                  wr0_ok_c;
  logic                  wr1_ok_c;

  // Writes to the hardwired zero register are dropped before they reach storage
  assign wr0_ok_c   = we0 && !((ZERO_REG != 0) && (wa0 == ZERO_ADDR));
  assign wr1_ok_c   = we1 && !((ZERO_REG != 0) && (wa1 == ZERO_ADDR));
  assign conflict_d = wr0_ok_c && wr1_ok_c && (wa0 == wa1);

  // Lane 1 is applied last so it overrides lane 0 on an address collision
  always_comb begin
    mem_d = mem_q;
    if (wr0_ok_c) mem_d[wa0] = wd0;
    if (wr1_ok_c) mem_d[wa1] = wd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) mem_q[i] <= '0;
      conflict_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      conflict_q <= conflict_d;
    end
  end

  assign wr_conflict = conflict_q;

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra_c;
    logic [DATA_WIDTH-1:0] rv_c;

    assign ra_c = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Zero register first, then the in-flight lane-1 and lane-0 writes, then storage
    always_comb begin
      rv_c = mem_q[ra_c];
      if ((ZERO_REG != 0) && (ra_c == ZERO_ADDR)) begin
        rv_c = '0;
      end else if ((BYPASS != 0) && we1 && (wa1 == ra_c)) begin
        rv_c = wd1;
      end else if ((BYPASS != 0) && we0 && (wa0 == ra_c)) begin
        rv_c = wd0;
      end
    end

    if (READ_LATENCY != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clock) begin
        if (reset) rd_q <= '0;
        else       rd_q <= rv_c;
      end
      assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end else begin : g_comb
      assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rv_c;
    end
  end

endmodule
